// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: PC-driven memory read, instruction hand-off, branch redirect.
// Optional memory-timeout watchdog enabled by defining FETCH_TIMEOUT_EN.
module fetch_ctrl #(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    output logic                  pc_inc,
    output logic                  pc_write,
    output logic [ADDR_WIDTH-1:0] pc_bus,
    input  logic                  br_valid,
    input  logic [ADDR_WIDTH-1:0] br_target,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  ir_valid,
    input  logic                  ir_ready,
    output logic [DATA_WIDTH-1:0] ir_data,
    output logic                  fetch_err
);

    typedef enum logic [2:0] {IDLE, ADDR, WAIT, HOLD, FLUSH} state_t;

    state_t state;
    logic   locked;
    logic   wait_expired;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("fetch_ctrl: TIMEOUT_CYCLES must be at least 1");
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wait_cnt;
    logic          err_q;

    // the limit cycle is the TIMEOUT_CYCLES-th WAIT cycle; an ack in it still wins
    assign wait_expired = (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign locked       = err_q;
    assign fetch_err    = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else if (state == ADDR) begin
            wait_cnt <= '0;
        end else if (state == WAIT && !br_valid && !mem_ack && !err_q) begin
            if (wait_expired)
                err_q <= 1'b1;
            else
                wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    assign wait_expired = 1'b0;
    assign locked       = 1'b0;
    assign fetch_err    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            pc_inc   <= 1'b0;
            pc_write <= 1'b0;
            pc_bus   <= '0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            ir_valid <= 1'b0;
            ir_data  <= '0;
        end else begin
            pc_inc   <= 1'b0;
            pc_write <= 1'b0;
            if (locked) begin
                state   <= IDLE;
                mem_req <= 1'b0;
            end else if (br_valid) begin
                // redirect beats a coincident ack: data and pc_inc are dropped
                pc_write <= 1'b1;
                pc_bus   <= br_target;
                mem_req  <= 1'b0;
                ir_valid <= 1'b0;
                state    <= FLUSH;
            end else begin
                case (state)
                    IDLE: if (run) state <= ADDR;
                    ADDR: begin
                        mem_addr <= pc_in;
                        mem_req  <= 1'b1;
                        state    <= WAIT;
                    end
                    WAIT: begin
                        if (mem_ack) begin
                            ir_data  <= mem_rdata;
                            ir_valid <= 1'b1;
                            pc_inc   <= 1'b1;
                            mem_req  <= 1'b0;
                            state    <= HOLD;
                        end else if (wait_expired) begin
                            mem_req <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                    HOLD: begin
                        if (ir_ready) begin
                            ir_valid <= 1'b0;
                            state    <= run ? ADDR : IDLE;
                        end
                    end
                    FLUSH:   state <= run ? ADDR : IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl; an external PC register follows pc_inc/pc_write.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset, run, br_valid, mem_ack, ir_ready;
    logic [11:0] br_target, pc_bus, mem_addr, pc;
    logic [15:0] mem_rdata, ir_data;
    logic        pc_inc, pc_write, mem_req, ir_valid, fetch_err;

    int checks   = 0;
    int failures = 0;

    fetch_ctrl #(.ADDR_WIDTH(12), .DATA_WIDTH(16), .TIMEOUT_CYCLES(15)) dut (
        .clk(clk), .reset(reset), .run(run), .pc_in(pc),
        .pc_inc(pc_inc), .pc_write(pc_write), .pc_bus(pc_bus),
        .br_valid(br_valid), .br_target(br_target),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_data(ir_data),
        .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    // program counter owned by the surrounding core
    always @(posedge clk) begin
        if (reset)         pc <= 12'h000;
        else if (pc_write) pc <= pc_bus;
        else if (pc_inc)   pc <= pc + 12'h001;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check("strobe_exclusive", 32'(pc_inc & pc_write), 32'd0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_pc_inc"},   32'(pc_inc),    32'd0);
        check({tag, "_pc_write"}, 32'(pc_write),  32'd0);
        check({tag, "_pc_bus"},   32'(pc_bus),    32'd0);
        check({tag, "_mem_req"},  32'(mem_req),   32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr),  32'd0);
        check({tag, "_ir_valid"}, 32'(ir_valid),  32'd0);
        check({tag, "_ir_data"},  32'(ir_data),   32'd0);
        check({tag, "_err"},      32'(fetch_err), 32'd0);
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; br_valid = 1'b0; br_target = '0;
        mem_ack = 1'b0; mem_rdata = '0; ir_ready = 1'b0;
        tick(); tick();
        check_idle("reset");
        reset = 1'b0;

        // basic fetch from 0x000, ack in second WAIT cycle
        run = 1'b1;
        tick(); check("addr_no_req", 32'(mem_req), 32'd0);
        tick(); check("wait1_req", 32'(mem_req), 32'd1);
        check("wait1_addr", 32'(mem_addr), 32'h000);
        tick(); check("wait2_req", 32'(mem_req), 32'd1);
        check("wait2_irv", 32'(ir_valid), 32'd0);
        mem_ack = 1'b1; mem_rdata = 16'hA5A5;
        tick(); mem_ack = 1'b0; mem_rdata = 16'h0000;
        check("f1_irv", 32'(ir_valid), 32'd1);
        check("f1_pc_inc", 32'(pc_inc), 32'd1);
        check("f1_data", 32'(ir_data), 32'hA5A5);
        check("f1_req", 32'(mem_req), 32'd0);

        // consumer stalls for 5 cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_irv", 32'(ir_valid), 32'd1);
            check("stall_data", 32'(ir_data), 32'hA5A5);
            check("stall_req", 32'(mem_req), 32'd0);
            check("stall_pc_inc", 32'(pc_inc), 32'd0);
        end
        ir_ready = 1'b1;
        tick(); ir_ready = 1'b0;
        check("handoff_irv", 32'(ir_valid), 32'd0);
        tick(); check("f2_req", 32'(mem_req), 32'd1);
        check("f2_addr", 32'(mem_addr), 32'h001);

        // redirect coincident with ack
        mem_ack = 1'b1; mem_rdata = 16'hBEEF; br_valid = 1'b1; br_target = 12'h123;
        tick(); mem_ack = 1'b0; br_valid = 1'b0;
        check("br_pc_write", 32'(pc_write), 32'd1);
        check("br_pc_bus", 32'(pc_bus), 32'h123);
        check("br_pc_inc", 32'(pc_inc), 32'd0);
        check("br_irv", 32'(ir_valid), 32'd0);
        check("br_req", 32'(mem_req), 32'd0);
        tick(); check("flush_done_pc_write", 32'(pc_write), 32'd0);
        check("flush_done_req", 32'(mem_req), 32'd0);
        tick(); check("br_fetch_req", 32'(mem_req), 32'd1);
        check("br_fetch_addr", 32'(mem_addr), 32'h123);
        check("br_data_kept", 32'(ir_data), 32'hA5A5);

        // redirect to 0xFFF, then wrap to 0x000
        br_valid = 1'b1; br_target = 12'hFFF;
        tick(); br_valid = 1'b0;
        tick(); tick();
        check("fff_addr", 32'(mem_addr), 32'hFFF);
        mem_ack = 1'b1; mem_rdata = 16'h1234;
        tick(); mem_ack = 1'b0;
        check("fff_data", 32'(ir_data), 32'h1234);
        check("fff_pc_inc", 32'(pc_inc), 32'd1);
        ir_ready = 1'b1;
        tick(); ir_ready = 1'b0;
        tick(); check("wrap_req", 32'(mem_req), 32'd1);
        check("wrap_addr", 32'(mem_addr), 32'h000);

        // reset in WAIT, then late ack
        reset = 1'b1;
        tick(); check_idle("rst_wait");
        reset = 1'b0; run = 1'b0; mem_ack = 1'b1; mem_rdata = 16'h5555;
        tick(); mem_ack = 1'b0;
        check_idle("late_ack");
        tick(); check_idle("late_ack2");

        // run dropped during WAIT: fetch completes, then idles
        run = 1'b1;
        tick(); tick(); run = 1'b0;
        check("r0_req", 32'(mem_req), 32'd1);
        mem_ack = 1'b1; mem_rdata = 16'h0F0F;
        tick(); mem_ack = 1'b0;
        check("r0_irv", 32'(ir_valid), 32'd1);
        check("r0_data", 32'(ir_data), 32'h0F0F);
        ir_ready = 1'b1;
        tick(); ir_ready = 1'b0;
        check("r0_handoff", 32'(ir_valid), 32'd0);
        tick(); check("r0_idle_req1", 32'(mem_req), 32'd0);
        tick(); check("r0_idle_req2", 32'(mem_req), 32'd0);

        // ack outside WAIT is ignored
        mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        tick(); mem_ack = 1'b0;
        check("stray_ack_irv", 32'(ir_valid), 32'd0);
        check("stray_ack_data", 32'(ir_data), 32'h0F0F);

`ifdef FETCH_TIMEOUT_EN
        run = 1'b1;
        tick(); tick();
        for (int i = 0; i < 14; i++) begin
            tick();
            check("to_req_held", 32'(mem_req), 32'd1);
        end
        tick();
        check("to_req", 32'(mem_req), 32'd0);
        check("to_err", 32'(fetch_err), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("to_locked_req", 32'(mem_req), 32'd0);
        end
        reset = 1'b1;
        tick(); reset = 1'b0; run = 1'b0;
        check("to_err_cleared", 32'(fetch_err), 32'd0);
`else
        run = 1'b1;
        tick(); tick();
        for (int i = 0; i < 20; i++) tick();
        check("no_to_req", 32'(mem_req), 32'd1);
        check("no_to_err", 32'(fetch_err), 32'd0);
        run = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
